pol_rom_loader: RTL and testbench

Sequencer that streams the fixed 52-word, 64-bit polynomial constant ROM into the multiplier's polynomial BRAM. It drives the ROM's relative address and absorbs the ROM's one-cycle registered read latency. It also writes each word to a destination BRAM window under a ready/stall handshake, and reports busy/done to the top-level multiplier controller.

---
 rtl/pol_rom_loader.sv | 149 ++++++++++++++
 tb/tb_pol_rom_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pol_rom_loader.sv
// Streams NUM_WORDS polynomial constants from a registered-output ROM into a BRAM window.
// Optional build macro POL_LOADER_CHECKSUM_EN adds a running XOR of all written words.
module pol_rom_loader #(
  parameter int NUM_WORDS = 52,
  parameter int ROM_AW    = 7,
  parameter int DATA_W    = 64,
  parameter int BRAM_AW   = 9,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic               bram_we,
  output logic [BRAM_AW-1:0] bram_addr,
  output logic [DATA_W-1:0]  bram_din,
  input  logic               bram_ready,
  output logic [DATA_W-1:0]  checksum
);

  localparam int IW = (NUM_WORDS < 2) ? 1 : $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_vld_p0, r_vld_p1;
  logic                r_out_vld, r_skid_vld;
  logic [DATA_W-1:0]   r_out_data, r_skid_data;
  logic [IW-1:0]       r_rd_idx, r_wr_idx;
  logic [ROM_AW-1:0]   r_rom_addr;
  logic                w_start_acc, w_acc, w_slot, w_issue, w_last_acc;
  logic [2:0]          w_inflight;
  logic                w_out_vld_nxt, w_skid_vld_nxt;
  logic [DATA_W-1:0]   w_out_data_nxt, w_skid_data_nxt, w_din;

  // The returning ROM word is presented directly; the output register only holds a stalled word.
  assign w_start_acc = start && (r_state == S_IDLE);
  assign bram_we     = r_out_vld | r_vld_p1;
  assign w_din       = r_out_vld ? r_out_data : rom_data;
  assign bram_din    = bram_we ? w_din : '0;
  assign bram_addr   = bram_we ? (BRAM_AW'(BASE_ADDR) + BRAM_AW'(r_wr_idx)) : '0;
  assign w_acc       = bram_we && bram_ready;
  assign w_last_acc  = w_acc && (r_wr_idx == IW'(NUM_WORDS - 1));
  assign rom_addr    = r_rom_addr;

  // Every issued, unaccepted word must fit in output + skid once it returns.
  assign w_inflight = 3'(r_vld_p0) + 3'(r_vld_p1) + 3'(r_out_vld) + 3'(r_skid_vld);
  assign w_slot     = (w_inflight - 3'(w_acc)) < 3'd2;
  assign w_issue    = (r_state == S_RUN) && w_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (NUM_WORDS == 1) ? S_DRAIN : S_RUN;
      S_RUN:   if (w_issue && (r_rd_idx == IW'(NUM_WORDS - 1))) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_last_acc) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_RUN) || (r_state == S_DRAIN);
    done = (r_state == S_DONE);
  end

  always_comb begin
    w_out_vld_nxt   = r_out_vld;
    w_out_data_nxt  = r_out_data;
    w_skid_vld_nxt  = r_skid_vld;
    w_skid_data_nxt = r_skid_data;
    if (w_acc) begin
      if (r_skid_vld) begin
        w_out_data_nxt = r_skid_data;
        w_skid_vld_nxt = 1'b0;
      end else if (r_out_vld) begin
        w_out_vld_nxt  = r_vld_p1;
        w_out_data_nxt = rom_data;
      end else begin
        w_out_vld_nxt  = 1'b0;
      end
    end else if (r_vld_p1) begin
      if (r_out_vld) begin
        w_skid_vld_nxt  = 1'b1;
        w_skid_data_nxt = rom_data;
      end else begin
        w_out_vld_nxt   = 1'b1;
        w_out_data_nxt  = rom_data;
      end
    end
  end

  // p0: address in front of the ROM, p1: ROM word on rom_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p0   <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_rd_idx   <= '0;
      r_wr_idx   <= '0;
      r_rom_addr <= '0;
    end else begin
      r_vld_p0   <= w_start_acc | w_issue;
      r_vld_p1   <= r_vld_p0;
      r_out_vld  <= w_out_vld_nxt;
      r_skid_vld <= w_skid_vld_nxt;
      if (w_start_acc) begin
        r_rom_addr <= '0;
        r_rd_idx   <= IW'(1);
        r_wr_idx   <= '0;
      end else begin
        if (w_issue) begin
          r_rom_addr <= ROM_AW'(r_rd_idx);
          r_rd_idx   <= r_rd_idx + IW'(1);
        end
        if (w_acc) r_wr_idx <= r_wr_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    r_out_data  <= w_out_data_nxt;
    r_skid_data <= w_skid_data_nxt;
  end

`ifdef POL_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_checksum <= '0;
    else if (w_start_acc) r_checksum <= '0;
    else if (w_acc)       r_checksum <= r_checksum ^ bram_din;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_pol_rom_loader.sv
// Randomized bench for pol_rom_loader: ROM model, write scoreboard and latency model.
module tb_pol_rom_loader;
  localparam int N    = 52;
  localparam int RAW  = 7;
  localparam int DW   = 64;
  localparam int BAW  = 9;
  localparam int BASE = 0;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           bram_ready = 1'b1;
  logic           busy, done, bram_we;
  logic [RAW-1:0] rom_addr;
  logic [DW-1:0]  rom_data;
  logic [BAW-1:0] bram_addr;
  logic [DW-1:0]  bram_din, checksum;

  pol_rom_loader #(.NUM_WORDS(N), .ROM_AW(RAW), .DATA_W(DW), .BRAM_AW(BAW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_ready(bram_ready), .checksum(checksum)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] rom [0:127];
  logic [DW-1:0] rom_xor;

  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor: accepted writes, stall cycles, done cycles, hold-while-stalled
  logic [BAW-1:0] q_addr[$];
  logic [DW-1:0]  q_din[$];
  int             stall_cnt = 0;
  int             done_cnt = 0;
  bit             prev_stall = 1'b0;
  logic [BAW-1:0] prev_addr;
  logic [DW-1:0]  prev_din;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("hold_we", bram_we, 1'b1);
        chk("hold_addr", bram_addr, prev_addr);
        chk("hold_din", bram_din, prev_din);
      end
      if (bram_we && bram_ready) begin
        q_addr.push_back(bram_addr);
        q_din.push_back(bram_din);
      end
      if (bram_we && !bram_ready) stall_cnt++;
      prev_stall = bram_we && !bram_ready;
      prev_addr  = bram_addr;
      prev_din   = bram_din;
    end
  end

  function automatic logic ready_for(input int m, input int c);
    if (m == 1) return !(c >= 6 && c <= 8);
    if (m == 2) return 1'($urandom_range(0, 1));
    return 1'b1;
  endfunction

  task automatic check_outputs_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_we"}, bram_we, 0);
    chk({nm, "_rom_addr"}, rom_addr, 0);
    chk({nm, "_bram_addr"}, bram_addr, 0);
    chk({nm, "_bram_din"}, bram_din, 0);
    chk({nm, "_checksum"}, checksum, 0);
  endtask

  // m: 0 no stall, 1 three-cycle stall on word 5, 2 random ready, 3 start re-pulsed at write 20
  task automatic do_transfer(input int m, input string nm);
    int lat;
    bit pulsed;
    q_addr.delete();
    q_din.delete();
    stall_cnt = 0;
    done_cnt  = 0;
    lat       = -1;
    pulsed    = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    bram_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_busy_e0"}, busy, 1);
    chk({nm, "_rom_addr_e0"}, rom_addr, 0);
    bram_ready = ready_for(m, 0);
    for (int c = 1; c <= 600; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
      bram_ready = ready_for(m, c);
      if (m == 3 && !pulsed && q_addr.size() == 20) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (lat < 0) chk({nm, "_done_timeout"}, 0, 1);
    else chk({nm, "_latency"}, lat, N + 1 + stall_cnt);
    if (m == 1) chk({nm, "_stall_cycles"}, stall_cnt, 3);
    bram_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_done_pulses"}, done_cnt, 1);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_nwrites"}, q_addr.size(), N);
    for (int i = 0; i < N && i < q_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", nm, i), q_addr[i], BAW'(BASE + i));
      chk($sformatf("%s_din%0d", nm, i), q_din[i], rom[i]);
    end
`ifdef POL_LOADER_CHECKSUM_EN
    chk({nm, "_checksum"}, checksum, rom_xor);
`else
    chk({nm, "_checksum"}, checksum, 0);
`endif
  endtask

  task automatic abort_test();
    bit hit;
    hit = 1'b0;
    q_addr.delete();
    q_din.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    bram_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (q_addr.size() == 30) begin
        hit = 1'b1;
        break;
      end
    end
    chk("abort_reached_write30", hit, 1);
    chk("abort_we_before_rst", bram_we, 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("abort_rst");
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 0);
    chk("abort_nwrites", q_addr.size(), 30);
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = '0;
    for (int i = 0; i < N; i++) rom[i] = (64'(i) + 64'd1) * 64'h9E3779B97F4A7C15 ^ 64'h5A5A_0F0F_3C3C_9696;
    rom[0]     = 64'hED3E8218895D8A50;
    rom[N - 1] = 64'hB655181B5B755C22;
    rom_xor = '0;
    for (int i = 0; i < N; i++) rom_xor ^= rom[i];

    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("idle");

    do_transfer(0, "nostall");
    chk("word0_const", q_din.size() > 0 ? q_din[0] : 64'd0, 64'hED3E8218895D8A50);
    chk("word51_const", q_din.size() > 51 ? q_din[51] : 64'd0, 64'hB655181B5B755C22);
    do_transfer(1, "stall3");
    do_transfer(2, "rand_a");
    do_transfer(2, "rand_b");
    do_transfer(3, "restart");
    abort_test();
    do_transfer(0, "after_rst");
    do_transfer(2, "rand_c");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
